// File: rtl/pulse_measurement_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_measurement_sequencer_if
// Brief    : Measurement input, control/status and byte-stream handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_measurement_sequencer_if #(
    parameter int COUNTER_BITS = 16
);
    logic                    PULSE;
    logic [COUNTER_BITS-1:0] TIME_HIGH;
    logic [COUNTER_BITS-1:0] TIME_LOW;
    logic [COUNTER_BITS-1:0] PERIOD;
    logic                    START;
    logic                    BUSY;
    logic                    TIMEOUT;
    logic [7:0]              DATA_OUT;
    logic                    DATA_VALID;
    logic                    DATA_READY;

    modport master (
        output PULSE, TIME_HIGH, TIME_LOW, PERIOD, START, DATA_READY,
        input  BUSY, TIMEOUT, DATA_OUT, DATA_VALID
    );

    modport slave (
        input  PULSE, TIME_HIGH, TIME_LOW, PERIOD, START, DATA_READY,
        output BUSY, TIMEOUT, DATA_OUT, DATA_VALID
    );
endinterface
`default_nettype wire

// File: rtl/pulse_measurement_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_measurement_sequencer
// Brief    : Discards one measurement, averages 2^AVG_LOG2 more, streams bytes
// Revision : 1.0 - initial release
// ============================================================================
module pulse_measurement_sequencer #(
    parameter int COUNTER_BITS   = 16,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic                    CLK,
    input  wire logic                    RST_N,
    pulse_measurement_sequencer_if.slave bus
);
    localparam int c_AW     = COUNTER_BITS + AVG_LOG2;
    localparam int c_CW     = AVG_LOG2 + 1;
    localparam int c_TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_PW     = 3 * COUNTER_BITS;
    localparam int c_NBYTES = c_PW / 8;
    localparam int c_BW     = $clog2(c_NBYTES);

    localparam logic [c_CW-1:0] c_LAST_CNT  = c_CW'((1 << AVG_LOG2) - 1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(c_NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISCARD = 2'd1,
        S_ACCUM   = 2'd2,
        S_STREAM  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_AW-1:0]    r_acc_th;
    logic [c_AW-1:0]    r_acc_tl;
    logic [c_AW-1:0]    r_acc_per;
    logic [c_CW-1:0]    r_count;
    logic [c_TW-1:0]    r_timer;
    logic               r_timeout;
    logic [c_PW-1:0]    r_shift;
    logic [7:0]         r_data_out;
    logic [c_BW-1:0]    r_byte_idx;

    logic               w_start_batch;
    logic               w_accept;
    logic               w_latch;
    logic               w_expire;
    logic               w_xfer;
    logic               w_timer_hit;
    logic [c_AW-1:0]    w_sum_th;
    logic [c_AW-1:0]    w_sum_tl;
    logic [c_AW-1:0]    w_sum_per;
    logic [COUNTER_BITS-1:0] w_avg_th;
    logic [COUNTER_BITS-1:0] w_avg_tl;
    logic [COUNTER_BITS-1:0] w_avg_per;
    logic [c_PW-1:0]    w_packed;

    // The sums include the current sample so the completing PULSE is averaged in
    assign w_sum_th    = r_acc_th  + c_AW'(bus.TIME_HIGH);
    assign w_sum_tl    = r_acc_tl  + c_AW'(bus.TIME_LOW);
    assign w_sum_per   = r_acc_per + c_AW'(bus.PERIOD);
    assign w_avg_th    = COUNTER_BITS'(w_sum_th  >> AVG_LOG2);
    assign w_avg_tl    = COUNTER_BITS'(w_sum_tl  >> AVG_LOG2);
    assign w_avg_per   = COUNTER_BITS'(w_sum_per >> AVG_LOG2);
    assign w_packed    = {w_avg_th, w_avg_tl, w_avg_per};
    assign w_timer_hit = !bus.PULSE && (r_timer == c_TO_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_start_batch = 1'b0;
        w_accept      = 1'b0;
        w_latch       = 1'b0;
        w_expire      = 1'b0;
        w_xfer        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_start_batch = 1'b1;
                    w_next_state  = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.PULSE) begin
                    w_next_state = S_ACCUM;
                end else if (w_timer_hit) begin
                    w_expire     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (bus.PULSE) begin
                    w_accept = 1'b1;
                    if (r_count == c_LAST_CNT) begin
                        w_latch      = 1'b1;
                        w_next_state = S_STREAM;
                    end
                end else if (w_timer_hit) begin
                    w_expire     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_STREAM: begin
                if (bus.DATA_READY) begin
                    w_xfer = 1'b1;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_acc_th   <= '0;
            r_acc_tl   <= '0;
            r_acc_per  <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_timeout  <= 1'b0;
            r_shift    <= '0;
            r_data_out <= '0;
            r_byte_idx <= '0;
        end else begin
            if (w_start_batch) begin
                r_acc_th  <= '0;
                r_acc_tl  <= '0;
                r_acc_per <= '0;
                r_count   <= '0;
                r_timer   <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == S_DISCARD || r_state == S_ACCUM) begin
                r_timer <= bus.PULSE ? '0 : r_timer + 1'b1;
            end

            if (w_accept) begin
                r_acc_th  <= w_sum_th;
                r_acc_tl  <= w_sum_tl;
                r_acc_per <= w_sum_per;
                r_count   <= r_count + 1'b1;
            end

            if (w_expire) begin
                r_timeout <= 1'b1;
            end

            // First byte is presented directly; the rest queue in the shifter
            if (w_latch) begin
                r_data_out <= w_packed[c_PW-1 -: 8];
                r_shift    <= w_packed << 8;
                r_byte_idx <= '0;
            end else if (w_xfer && (r_byte_idx != c_LAST_BYTE)) begin
                r_data_out <= r_shift[c_PW-1 -: 8];
                r_shift    <= r_shift << 8;
                r_byte_idx <= r_byte_idx + 1'b1;
            end
        end
    end

    assign bus.BUSY       = (r_state != S_IDLE);
    assign bus.DATA_VALID = (r_state == S_STREAM);
    assign bus.DATA_OUT   = r_data_out;
    assign bus.TIMEOUT    = r_timeout;

endmodule
`default_nettype wire

// File: doc/pulse_measurement_sequencer.md
Name: pulse_measurement_sequencer

Overview:
Controller between frequency_counter and the 8-bit output pins. On a START request it discards the first (possibly partial) measurement. It then accumulates 2^AVG_LOG2 consecutive measurements of TIME_HIGH, TIME_LOW and PERIOD, and averages them. The averaged results go out as a byte stream over a valid/ready handshake, so the host no longer drives the mux select manually. A missing or stalled input signal ends the batch with a sticky timeout flag.

Parameters:
COUNTER_BITS, 16, width of TIME_HIGH/TIME_LOW/PERIOD; must be a multiple of 8.
AVG_LOG2, 2, log2 of the number of measurements averaged (0 = single shot); legal range 0..4.
TIMEOUT_CYCLES, 65535, CLK cycles allowed between PULSE strobes before the batch aborts; must be >= 1.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RST_N  in  1  synchronous active-low reset.
PULSE  in  1  one-cycle strobe from frequency_counter: new TIME_HIGH/TIME_LOW/PERIOD valid this cycle.
TIME_HIGH  in  COUNTER_BITS  high time of the last full period, in clocks.
TIME_LOW  in  COUNTER_BITS  low time of the last full period, in clocks.
PERIOD  in  COUNTER_BITS  last full period, in clocks.
START  in  1  level; sampled in IDLE only; begins a batch.
BUSY  out  1  high in every state except IDLE.
TIMEOUT  out  1  sticky abort flag.
DATA_OUT  out  8  current stream byte.
DATA_VALID  out  1  DATA_OUT holds a valid byte.
DATA_READY  in  1  consumer accepts the byte.

Behaviour:
- Reset (RST_N low at a rising edge): on the next edge state=IDLE, and BUSY=0, TIMEOUT=0, DATA_VALID=0, DATA_OUT=0.
- Reset applies from any state, including mid-stream. A partially sent stream is dropped, with no further bytes.
- FSM states: IDLE, DISCARD, ACCUM, STREAM.
- IDLE:
  - START=1 -> DISCARD; clear accumulators, measurement count and timeout counter; clear TIMEOUT.
  - START in any other state is ignored.
- DISCARD: the first PULSE goes -> ACCUM; its data is not accumulated.
- ACCUM:
  - Each PULSE adds TIME_HIGH, TIME_LOW and PERIOD into three accumulators of COUNTER_BITS+AVG_LOG2 bits each (no overflow possible).
  - Each PULSE also increments the measurement count.
  - On the PULSE that completes 2^AVG_LOG2 samples, latch the averages (sum including that sample) >> AVG_LOG2, truncating. Enter STREAM with DATA_VALID=1 on the next cycle.
- Timeout, in DISCARD and ACCUM:
  - The counter resets on entry and on every PULSE, and increments otherwise.
  - When TIMEOUT_CYCLES consecutive non-PULSE cycles have elapsed: TIMEOUT=1, go to IDLE, no stream.
  - A PULSE in the same cycle as expiry wins: no timeout.
  - TIMEOUT stays set until reset or the next accepted START.
- STREAM:
  - Byte order is MSB-first per field: TIME_HIGH, then TIME_LOW, then PERIOD. That is 3*COUNTER_BITS/8 bytes; the default is 6.
  - Transfer occurs on a cycle where DATA_VALID=1 and DATA_READY=1. The next byte is presented the following cycle.
  - DATA_OUT and DATA_VALID stay stable while DATA_READY=0; no timeout applies in STREAM.
  - After the last transfer: DATA_VALID=0, state=IDLE, BUSY=0 on the next cycle.
  - PULSE is ignored in STREAM and IDLE.
- DATA_VALID is high only in STREAM. DATA_OUT holds its last value outside STREAM.
- Throughput: with DATA_READY tied high, one byte per cycle.
- START held high through IDLE re-arms immediately. The earliest next DISCARD entry is the cycle after returning to IDLE.

Test Plan:
1. AVG_LOG2=2, DATA_READY=1, START. Stimulus: discard PULSE, then 4 PULSEs with TH=100,102,104,106, TL=50 each, PER=150,152,154,156. Required stream: 0x00,0x67,0x00,0x32,0x00,0x99 (TH avg 103, TL 50, PER 153) on consecutive cycles; BUSY falls after the last byte.
2. Truncation: AVG_LOG2=1, TH samples 7 and 8 -> TH bytes 0x00,0x07.
3. Backpressure: DATA_READY low for 5 cycles at byte 2 -> DATA_OUT/DATA_VALID held constant; stream completes with correct bytes and no loss or duplication.
4. Timeout: TIMEOUT_CYCLES=20, START, one discard PULSE, then no PULSE -> after 20 idle cycles TIMEOUT=1, BUSY=0, DATA_VALID never asserted. A new START clears TIMEOUT.
5. Timeout tie: PULSE arrives exactly on the expiry cycle -> no timeout; accumulation continues.
6. Reset mid-stream: RST_N low for 1 cycle after byte 3 -> next cycle IDLE, all outputs 0. START is ignored during STREAM; a START after reset starts a fresh batch with a discard.
